imm_gen_pipe: RTL and testbench

- Parametrised, pipelined immediate generator for the pipelined core.
- Successor to the single-cycle combinational extender: all six RV immediate formats, XLEN 32/64, 1–2 register stages, valid/ready handshake, flush.
- Sits between decode and execute. Accepts the raw instruction plus a format select, and delivers a sign/zero-extended immediate aligned with its valid.

---
 rtl/imm_gen_pipe.sv | 155 +++++++++++++++
 tb/tb_imm_gen_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RV immediate generator: six formats, XLEN 32/64, 1-2 register stages, valid/ready.
// Define IMM_AUTO_DECODE_EN to derive the format from the opcode instead of imm_src.
module imm_gen_pipe #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output logic            imm_err
);

  typedef enum logic [2:0] {
    FmtI     = 3'b000,
    FmtS     = 3'b001,
    FmtB     = 3'b010,
    FmtU     = 3'b011,
    FmtJ     = 3'b100,
    FmtShamt = 3'b101,
    FmtRsvd0 = 3'b110,
    FmtRsvd1 = 3'b111
  } fmt_e;

  fmt_e fmt;

`ifdef IMM_AUTO_DECODE_EN
  logic unused_src;
  assign unused_src = ^imm_src;

  always_comb begin
    fmt = FmtRsvd0;
    case (instr[6:0])
      // funct3 001/101 are the shift-immediate encodings
      7'b0010011:             fmt = (instr[13:12] == 2'b01) ? FmtShamt : FmtI;
      7'b0000011, 7'b1100111: fmt = FmtI;
      7'b0100011:             fmt = FmtS;
      7'b1100011:             fmt = FmtB;
      7'b0110111, 7'b0010111: fmt = FmtU;
      7'b1101111:             fmt = FmtJ;
      default:                fmt = FmtRsvd0;
    endcase
  end
`else
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];
  assign fmt = fmt_e'(imm_src);
`endif

  logic [XLEN-1:0] ext_imm;
  logic            ext_err;

  always_comb begin
    ext_imm = '0;
    ext_err = 1'b0;
    case (fmt)
      FmtI:     ext_imm = XLEN'($signed(instr[31:20]));
      FmtS:     ext_imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      FmtB:     ext_imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      FmtU:     ext_imm = XLEN'($signed({instr[31:12], 12'b0}));
      FmtJ:     ext_imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      FmtShamt: ext_imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      default:  ext_err = 1'b1;
    endcase
  end

  logic            s1_valid_q, s1_valid_d;
  logic [XLEN-1:0] s1_imm_q, s1_imm_d;
  logic            s1_err_q, s1_err_d;
  logic            s1_adv;
  logic            in_fire;

  assign in_ready = !s1_valid_q | s1_adv;
  assign in_fire  = in_valid & in_ready & !flush;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_imm_d   = s1_imm_q;
    s1_err_d   = s1_err_q;
    if (flush) begin
      s1_valid_d = 1'b0;
    end else if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_imm_d   = ext_imm;
      s1_err_d   = ext_err;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_imm_q   <= '0;
      s1_err_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_imm_q   <= s1_imm_d;
      s1_err_q   <= s1_err_d;
    end
  end

  if (STAGES == 2) begin : g_two
    logic            s2_valid_q, s2_valid_d;
    logic [XLEN-1:0] s2_imm_q, s2_imm_d;
    logic            s2_err_q, s2_err_d;
    logic            s2_adv;

    assign s2_adv = !s2_valid_q | out_ready;
    assign s1_adv = s2_adv;

    always_comb begin
      s2_valid_d = s2_valid_q;
      s2_imm_d   = s2_imm_q;
      s2_err_d   = s2_err_q;
      if (flush) begin
        s2_valid_d = 1'b0;
      end else if (s2_adv) begin
        s2_valid_d = s1_valid_q;
        if (s1_valid_q) begin
          s2_imm_d = s1_imm_q;
          s2_err_d = s1_err_q;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        s2_valid_q <= 1'b0;
        s2_imm_q   <= '0;
        s2_err_q   <= 1'b0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_imm_q   <= s2_imm_d;
        s2_err_q   <= s2_err_d;
      end
    end

    assign out_valid = s2_valid_q;
    assign imm_out   = s2_imm_q;
    assign imm_err   = s2_err_q;
  end else begin : g_one
    assign s1_adv    = out_ready;
    assign out_valid = s1_valid_q;
    assign imm_out   = s1_imm_q;
    assign imm_err   = s1_err_q;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN32/1-stage and XLEN64/2-stage instances checked against a
// queue-based behavioural model plus directed literal expectations.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_err;
  logic [31:0] a_instr;
  logic [2:0]  a_src;
  logic [31:0] a_imm;

  logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_err;
  logic [31:0] b_instr;
  logic [2:0]  b_src;
  logic [63:0] b_imm;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) u_a (
    .clk(clk), .reset_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .instr(a_instr), .imm_src(a_src), .flush(a_flush), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .imm_out(a_imm), .imm_err(a_err)
  );

  imm_gen_pipe #(.XLEN(64), .STAGES(2)) u_b (
    .clk(clk), .reset_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .instr(b_instr), .imm_src(b_src), .flush(b_flush), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .imm_out(b_imm), .imm_err(b_err)
  );

  typedef struct {
    logic [63:0] imm;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q [2][$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int eff_fmt(input logic [31:0] ins, input logic [2:0] src);
`ifdef IMM_AUTO_DECODE_EN
    case (ins[6:0])
      7'h13:        return (ins[14:12] == 3'b001 || ins[14:12] == 3'b101) ? 5 : 0;
      7'h03, 7'h67: return 0;
      7'h23:        return 1;
      7'h63:        return 2;
      7'h37, 7'h17: return 3;
      7'h6F:        return 4;
      default:      return 6;
    endcase
`else
    return int'(src);
`endif
  endfunction

  // Immediate value as arithmetic on the sign-extended word; returns {err, imm}.
  function automatic logic [64:0] model(input logic [31:0] ins, input logic [2:0] src,
                                        input bit x64);
    longint      s, t;
    logic [63:0] r;
    logic        err;
    s   = longint'($signed(ins));
    r   = '0;
    err = 1'b0;
    case (eff_fmt(ins, src))
      0: r = s >>> 20;
      1: begin t = s >>> 25; r = (t << 5) | 64'(ins[11:7]); end
      2: begin
        t = s >>> 31;
        r = (t << 12) | (64'(ins[7]) << 11) | (64'(ins[30:25]) << 5) | (64'(ins[11:8]) << 1);
      end
      3: begin t = s >>> 12; r = t << 12; end
      4: begin
        t = s >>> 31;
        r = (t << 20) | (64'(ins[19:12]) << 12) | (64'(ins[20]) << 11) | (64'(ins[30:21]) << 1);
      end
      5: r = x64 ? 64'(ins[25:20]) : 64'(ins[24:20]);
      default: err = 1'b1;
    endcase
    if (!x64) r[63:32] = '0;
    return {err, r};
  endfunction

  task automatic mon(input int id, input int stages, input logic in_v, input logic in_r,
                     input logic out_v, input logic out_r, input logic fl,
                     input logic [63:0] imm, input logic err, input logic [31:0] ins,
                     input logic [2:0] src, input bit x64);
    exp_t        e;
    logic [64:0] m;
    bit          due;
    check($sformatf("d%0d_in_ready", id), 64'(in_r), 64'((q[id].size() < stages) || out_r));
    due = (q[id].size() > 0) && ((cyc - q[id][0].cyc) >= stages);
    check($sformatf("d%0d_out_valid", id), 64'(out_v), 64'(due));
    if (out_v && q[id].size() > 0) begin
      e = q[id][0];
      check($sformatf("d%0d_imm", id), imm, e.imm);
      check($sformatf("d%0d_err", id), 64'(err), 64'(e.err));
    end
    if (!rst_n) begin
      q[id].delete();
    end else begin
      if (out_v && out_r && q[id].size() > 0) void'(q[id].pop_front());
      if (fl) begin
        q[id].delete();
      end else if (in_v && in_r) begin
        m = model(ins, src, x64);
        e.imm = m[63:0];
        e.err = m[64];
        e.cyc = cyc;
        q[id].push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, 1, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush, 64'(a_imm), a_err,
          a_instr, a_src, 1'b0);
      mon(1, 2, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush, b_imm, b_err,
          b_instr, b_src, 1'b1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] X1 = 32'h0010_0093;
  localparam logic [31:0] X2 = 32'h0020_0093;
  localparam logic [31:0] X3 = 32'hFFF0_0093;

  initial begin
    logic [64:0] m;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_instr = '0; a_src = '0; a_flush = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_instr = '0; b_src = '0; b_flush = 1'b0; b_out_ready = 1'b1;
    repeat (3) step();
    check("rst_a_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_imm", 64'(a_imm), 64'd0);
    check("rst_a_err", 64'(a_err), 64'd0);
    check("rst_b_valid", 64'(b_out_valid), 64'd0);
    check("rst_b_imm", b_imm, 64'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();
    check("post_rst_a_ready", 64'(a_in_ready), 64'd1);
    check("post_rst_b_ready", 64'(b_in_ready), 64'd1);

    // Pin the model to hand-computed values.
    m = model(32'h0220_8263, 3'd2, 1'b0);
    check("model_B", m[63:0], 64'h24);
    m = model(32'h0020_2223, 3'd1, 1'b0);
    check("model_S", m[63:0], 64'h4);
    m = model(32'hFE1F_F06F, 3'd4, 1'b1);
    check("model_J64", m[63:0], 64'hFFFF_FFFF_FFFF_FFE0);
    m = model(32'h0300_1013 | 32'h00F0_0000, 3'd5, 1'b0);
    check("model_SHAMT32", m[63:0], 64'h1F);

    // Back-to-back on the 32-bit single-stage instance.
    a_in_valid = 1'b1; a_src = 3'd0; a_instr = 32'h01C0_0113;
    step(); check("t1_v0", 64'(a_out_valid), 64'd1); check("t1_i0", 64'(a_imm), 64'h1C);
    a_src = 3'd1; a_instr = 32'h0020_2223;
    step(); check("t1_i1", 64'(a_imm), 64'h4);
    a_src = 3'd0; a_instr = 32'h0040_2103;
    step(); check("t1_i2", 64'(a_imm), 64'h4);
    a_src = 3'd2; a_instr = 32'h0220_8263;
    step(); check("t1_i3", 64'(a_imm), 64'h24); check("t1_e3", 64'(a_err), 64'd0);
    a_in_valid = 1'b0;
    step(); check("t1_drain", 64'(a_out_valid), 64'd0);

    // 64-bit formats through the two-stage instance.
    b_in_valid = 1'b1; b_src = 3'd3; b_instr = 32'h1234_50B7;
    step(); b_in_valid = 1'b0;
    step(); check("t2_Uv", 64'(b_out_valid), 64'd1); check("t2_U", b_imm, 64'h1234_5000);
    b_in_valid = 1'b1; b_src = 3'd4; b_instr = 32'hFE1F_F06F;
    step(); b_src = 3'd5; b_instr = 32'h03F0_1013;
    step(); check("t2_J", b_imm, 64'hFFFF_FFFF_FFFF_FFE0);
    b_in_valid = 1'b0;
    step(); check("t2_SH", b_imm, 64'h3F);
    step();

    // Backpressure: two accepted, third refused, output held.
    b_out_ready = 1'b0; b_src = 3'd0;
    b_in_valid = 1'b1; b_instr = X1; step();
    b_instr = X2; step();
    b_instr = X3;
    check("t3_full_ready", 64'(b_in_ready), 64'd0);
    step(); check("t3_hold0", b_imm, 64'h1); check("t3_hold_v", 64'(b_out_valid), 64'd1);
    step(); check("t3_hold1", b_imm, 64'h1); check("t3_still_full", 64'(b_in_ready), 64'd0);
    b_out_ready = 1'b1; #1;
    check("t3_ready_up", 64'(b_in_ready), 64'd1);
    step(); b_in_valid = 1'b0; check("t3_o2", b_imm, 64'h2);
    step(); check("t3_o3", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    step(); check("t3_empty", 64'(b_out_valid), 64'd0);

    // Flush with two entries in flight and a new input on the same cycle.
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_instr = X1; step();
    b_instr = X2; step();
    b_flush = 1'b1; b_instr = X3; step();
    b_flush = 1'b0; b_in_valid = 1'b0;
    check("t4_valid", 64'(b_out_valid), 64'd0);
    check("t4_ready", 64'(b_in_ready), 64'd1);
    b_out_ready = 1'b1;
    repeat (3) step();
    check("t4_nothing", 64'(b_out_valid), 64'd0);

    // Reserved format.
    a_in_valid = 1'b1; a_src = 3'd6; a_instr = 32'h1234_5678;
    step(); a_in_valid = 1'b0;
    check("t5_v", 64'(a_out_valid), 64'd1);
    check("t5_imm", 64'(a_imm), 64'd0);
    check("t5_err", 64'(a_err), 64'd1);
    step();

    // Reset mid-stream discards a stalled entry.
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_src = 3'd0; a_instr = 32'h01C0_0113;
    step(); a_in_valid = 1'b0;
    check("t6_stalled", 64'(a_out_valid), 64'd1);
    rst_n = 1'b0;
    step();
    check("t6_rst_v", 64'(a_out_valid), 64'd0);
    check("t6_rst_imm", 64'(a_imm), 64'd0);
    rst_n = 1'b1; a_out_ready = 1'b1;
    step(); check("t6_after", 64'(a_out_valid), 64'd0);

`ifdef IMM_AUTO_DECODE_EN
    a_in_valid = 1'b1; a_src = 3'd7; a_instr = 32'h0220_8263;
    step(); check("t7_B", 64'(a_imm), 64'h24); check("t7_Be", 64'(a_err), 64'd0);
    a_instr = 32'h0000_007F;
    step(); check("t7_bad", 64'(a_err), 64'd1);
    a_in_valid = 1'b0;
    step();
`endif

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
